// File: rtl/rr_arbiter_2x1_nbit_pkg.sv
// Shared source encoding and the round-robin select rule for two-input arbiters.
package rr_arbiter_2x1_nbit_pkg;

    localparam logic SRC_W0 = 1'b0;
    localparam logic SRC_W1 = 1'b1;

    // Source 1 wins when it is alone, or on a tie when source 0 was served last.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        return v1 & (!v0 | (last == SRC_W0));
    endfunction

endpackage

// File: rtl/mux_2x1_nbit.sv
// n-bit two-input multiplexer: f = s ? w1 : w0.
module mux_2x1_nbit #(
    parameter int n = 3
) (
    input  logic [n-1:0] w0,
    input  logic [n-1:0] w1,
    input  logic         s,
    output logic [n-1:0] f
);

    assign f = s ? w1 : w0;

endmodule

// File: rtl/rr_arbiter_2x1_nbit.sv
// Round-robin merge of two valid/ready streams into one registered output stage.
module rr_arbiter_2x1_nbit
    import rr_arbiter_2x1_nbit_pkg::*;
#(
    parameter int n = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] w0,
    input  logic         w0_valid,
    output logic         w0_ready,
    input  logic [n-1:0] w1,
    input  logic         w1_valid,
    output logic         w1_ready,
    output logic         s,
    output logic [n-1:0] f,
    output logic         f_src,
    output logic         f_valid,
    input  logic         f_ready
);

    logic         last;
    logic         accept;
    logic         xfer;
    logic [n-1:0] mux_f;

    mux_2x1_nbit #(.n(n)) u_mux (
        .w0 (w0),
        .w1 (w1),
        .s  (s),
        .f  (mux_f)
    );

    // The output stage can take a word when empty or when it drains this same cycle.
    assign accept   = !rst & (!f_valid | f_ready);
    assign s        = rr_pick(w0_valid, w1_valid, last);
    assign w0_ready = accept & !s;
    assign w1_ready = accept & s;
    assign xfer     = (w0_valid & w0_ready) | (w1_valid & w1_ready);

    // Priority pointer moves only on a real transfer, so idle cycles keep fairness.
    always_ff @(posedge clk) begin
        if (rst) begin
            f       <= '0;
            f_src   <= SRC_W0;
            f_valid <= 1'b0;
            last    <= SRC_W1;
        end else if (xfer) begin
            f       <= mux_f;
            f_src   <= s;
            f_valid <= 1'b1;
            last    <= s;
        end else if (f_ready) begin
            f_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_2x1_nbit.sv
// Directed vector table plus randomized run against a behavioural arbiter model.
module tb_rr_arbiter_2x1_nbit;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] w0, w1, f;
    logic       w0_valid, w1_valid, w0_ready, w1_ready;
    logic       s, f_src, f_valid, f_ready;

    int tests = 0;
    int fails = 0;

    // Behavioural model state: held output word and the source served most recently.
    int mValid, mData, mSrc, mLast;

    typedef struct {
        int rst, w0v, w0, w1v, w1, fr;
        int es, ew0r, ew1r, efv, ef, efsrc;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    rr_arbiter_2x1_nbit #(.n(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .w0       (w0),
        .w0_valid (w0_valid),
        .w0_ready (w0_ready),
        .w1       (w1),
        .w1_valid (w1_valid),
        .w1_ready (w1_ready),
        .s        (s),
        .f        (f),
        .f_src    (f_src),
        .f_valid  (f_valid),
        .f_ready  (f_ready)
    );

    task automatic applyStimulus(input int r, input int v0, input int d0,
                                 input int v1, input int d1, input int fr);
        rst      = 1'(r);
        w0_valid = 1'(v0);
        w0       = 3'(d0);
        w1_valid = 1'(v1);
        w1       = 3'(d1);
        f_ready  = 1'(fr);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Grant chosen from the fairness rules: a lone requester wins; a tie goes to the other one.
    function automatic int modelGrant(input int v0, input int v1);
        if (v0 != 0 && v1 != 0) return (mLast == 0) ? 1 : 0;
        if (v1 != 0) return 1;
        return 0;
    endfunction

    function automatic int modelAccept(input int r, input int fr);
        return (r == 0 && (mValid == 0 || fr != 0)) ? 1 : 0;
    endfunction

    task automatic modelClock(input int r, input int v0, input int d0,
                              input int v1, input int d1, input int fr);
        int g, acc;
        g   = modelGrant(v0, v1);
        acc = modelAccept(r, fr);
        if (r != 0) begin
            mValid = 0; mData = 0; mSrc = 0; mLast = 1;
        end else if (acc != 0 && ((g == 0 && v0 != 0) || (g == 1 && v1 != 0))) begin
            mValid = 1; mData = (g == 0) ? d0 : d1; mSrc = g; mLast = g;
        end else if (fr != 0) begin
            mValid = 0;
        end
    endtask

    task automatic runVector(input vec_t v, input int idx);
        applyStimulus(v.rst, v.w0v, v.w0, v.w1v, v.w1, v.fr);
        checkOutput($sformatf("vec%0d s", idx), int'(s), v.es);
        checkOutput($sformatf("vec%0d w0_ready", idx), int'(w0_ready), v.ew0r);
        checkOutput($sformatf("vec%0d w1_ready", idx), int'(w1_ready), v.ew1r);
        @(posedge clk);
        modelClock(v.rst, v.w0v, v.w0, v.w1v, v.w1, v.fr);
        #1;
        checkOutput($sformatf("vec%0d f_valid", idx), int'(f_valid), v.efv);
        checkOutput($sformatf("vec%0d f", idx), int'(f), v.ef);
        checkOutput($sformatf("vec%0d f_src", idx), int'(f_src), v.efsrc);
    endtask

    task automatic runRandom(input int idx);
        int r, v0, d0, v1, d1, fr, g, acc;
        r  = ($urandom_range(0, 49) == 0) ? 1 : 0;
        v0 = int'($urandom_range(0, 1));
        v1 = int'($urandom_range(0, 1));
        d0 = int'($urandom_range(0, 7));
        d1 = int'($urandom_range(0, 7));
        fr = ($urandom_range(0, 3) != 0) ? 1 : 0;
        applyStimulus(r, v0, d0, v1, d1, fr);
        g   = modelGrant(v0, v1);
        acc = modelAccept(r, fr);
        checkOutput($sformatf("rnd%0d s", idx), int'(s), g);
        checkOutput($sformatf("rnd%0d w0_ready", idx), int'(w0_ready), (acc != 0 && g == 0) ? 1 : 0);
        checkOutput($sformatf("rnd%0d w1_ready", idx), int'(w1_ready), (acc != 0 && g == 1) ? 1 : 0);
        @(posedge clk);
        modelClock(r, v0, d0, v1, d1, fr);
        #1;
        checkOutput($sformatf("rnd%0d f_valid", idx), int'(f_valid), mValid);
        if (mValid != 0) begin
            checkOutput($sformatf("rnd%0d f", idx), int'(f), mData);
            checkOutput($sformatf("rnd%0d f_src", idx), int'(f_src), mSrc);
        end
    endtask

    initial begin
        // rst  w0v w0 w1v w1 fr | s  w0r w1r | fv  f  fsrc
        tbl.push_back('{1, 1, 2, 1, 3, 1,  0, 0, 0,  0, 0, 0});  // reset held with both valid
        tbl.push_back('{1, 1, 2, 1, 3, 1,  0, 0, 0,  0, 0, 0});
        tbl.push_back('{0, 1, 5, 0, 0, 1,  0, 1, 0,  1, 5, 0});  // single source
        tbl.push_back('{0, 0, 0, 0, 0, 1,  0, 1, 0,  0, 5, 0});  // drain, word held
        tbl.push_back('{0, 1, 1, 1, 6, 1,  1, 0, 1,  1, 6, 1});  // tie alternation
        tbl.push_back('{0, 1, 1, 1, 6, 1,  0, 1, 0,  1, 1, 0});
        tbl.push_back('{0, 1, 1, 1, 6, 1,  1, 0, 1,  1, 6, 1});
        tbl.push_back('{0, 1, 1, 1, 6, 1,  0, 1, 0,  1, 1, 0});
        tbl.push_back('{0, 1, 3, 0, 0, 1,  0, 1, 0,  1, 3, 0});  // load 3 then stall
        tbl.push_back('{0, 1, 1, 1, 6, 0,  1, 0, 0,  1, 3, 0});
        tbl.push_back('{0, 1, 1, 1, 6, 0,  1, 0, 0,  1, 3, 0});
        tbl.push_back('{0, 1, 1, 1, 6, 0,  1, 0, 0,  1, 3, 0});
        tbl.push_back('{0, 1, 1, 1, 6, 1,  1, 0, 1,  1, 6, 1});  // release backpressure
        tbl.push_back('{0, 1, 1, 1, 6, 1,  0, 1, 0,  1, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 7, 1,  1, 0, 1,  1, 7, 1});  // grant w1 then idle
        tbl.push_back('{0, 0, 0, 0, 0, 1,  0, 1, 0,  0, 7, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 1,  0, 1, 0,  0, 7, 1});
        tbl.push_back('{0, 1, 2, 1, 5, 1,  0, 1, 0,  1, 2, 0});  // idle kept w0 priority
        tbl.push_back('{0, 1, 4, 0, 0, 1,  0, 1, 0,  1, 4, 0});  // reset during stall
        tbl.push_back('{0, 0, 0, 1, 1, 0,  1, 0, 0,  1, 4, 0});
        tbl.push_back('{1, 0, 0, 1, 1, 0,  1, 0, 0,  0, 0, 0});
        tbl.push_back('{0, 1, 6, 1, 2, 0,  0, 1, 0,  1, 6, 0});  // first tie after reset -> w0
        tbl.push_back('{0, 1, 6, 1, 2, 0,  1, 0, 0,  1, 6, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1,  0, 1, 0,  0, 6, 0});

        mValid = 0; mData = 0; mSrc = 0; mLast = 1;
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        foreach (tbl[i]) runVector(tbl[i], i);
        for (int i = 0; i < 400; i++) runRandom(i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_2x1_nbit.md
Name: rr_arbiter_2x1_nbit

Overview:
- Two-source, n-bit stream arbiter with valid/ready handshakes on both inputs and on the output.
- Picks one source per cycle by round-robin and drives the select of the team's mux_2x1_nbit datapath.
- Registers the selected word with its source tag into a one-entry output stage.
- Sits directly upstream of consumers that expect one merged stream from two producers.

Parameters:
- n, 3, data width of w0, w1 and f.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- w0  input  n  source 0 data.
- w0_valid  input  1  source 0 word present.
- w0_ready  output  1  source 0 word accepted this cycle.
- w1  input  n  source 1 data.
- w1_valid  input  1  source 1 word present.
- w1_ready  output  1  source 1 word accepted this cycle.
- s  output  1  combinational grant/select (0 = w0, 1 = w1); drives the mux select.
- f  output  n  registered output data.
- f_src  output  1  source of the word held in f.
- f_valid  output  1  f holds a valid word.
- f_ready  input  1  downstream accepts f this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state updates only on the rising clk edge.
- Reset values: f=0, f_src=0, f_valid=0, last=1 (internal last-granted pointer).
  - While rst=1: w0_ready=0 and w1_ready=0, so no transfer occurs.
  - A held output word is discarded on reset; no partial state survives.
- accept = !f_valid | f_ready (output stage empty or draining this cycle). Forced to 0 while rst=1.
- Select rule:
  - s = w1_valid & (!w0_valid | last==0).
  - Only one source valid: that source is granted.
  - Both valid: grant the source that is not last.
  - Neither valid: s=0.
- Readys:
  - w0_ready = accept & !s.
  - w1_ready = accept & s.
  - Readys may depend on valids; sources must not depend on ready to raise valid.
- Transfer (source valid & ready at the clock edge): f <= mux(w0, w1, s), f_src <= s, f_valid <= 1, last <= s.
- No input transfer but f_ready=1 with f_valid=1: f_valid <= 0. f and f_src hold their old value.
- Stall (f_valid=1, f_ready=0): f, f_src and f_valid hold stable; both readys are 0; last unchanged.
- Timing:
  - Latency is 1 cycle from input transfer to f_valid.
  - Sustained throughput is 1 word per cycle, including simultaneous output drain and input load.
- Fairness:
  - With both sources continuously valid and f_ready=1, grants alternate strictly 0,1,0,1,...
  - The first tie after reset grants w0.
- last updates only on an actual transfer. Idle cycles keep priority.
- The data path is pure pass-through; no width change; no arithmetic.

Decomposition:
- No shared package needed. A localparam SRC_W0=0 / SRC_W1=1 encoding may live in the project's common defines if other arbiters reuse it.
- Sub-module: instantiate the existing mux_2x1_nbit (parameter n) for the data select, driven by s.
- Control (last, accept, readys) and the output register stay in this module.

Test Plan (n=3):
- Reset: rst=1 for 2 cycles with w0_valid=w1_valid=1 -> f_valid=0, f=0, f_src=0, w0_ready=w1_ready=0. Release -> first cycle grants w0 (s=0).
- Single source: w0_valid=1, w0=5, w1_valid=0, f_ready=1 -> next cycle f=5, f_src=0, f_valid=1. Drop w0_valid -> following cycle f_valid=0.
- Round-robin tie: both valid for 4 cycles, w0=1, w1=6, f_ready=1 -> f sequence 1,6,1,6 with f_src 0,1,0,1. No source is accepted twice in a row.
- Backpressure: f_valid=1, f=3, f_ready=0 for 3 cycles while both inputs valid -> f=3 stable, readys=0, last unchanged. Raise f_ready -> next grant per the last rule, one transfer per cycle.
- Idle keeps priority: grant w1 (w1=7), then idle 2 cycles, then both valid -> w0 granted (last was 1).
- Reset mid-stall: f_valid=1, f=4, f_ready=0, assert rst one cycle -> f_valid=0, f=0, last=1. Next tie grants w0.
